// File: rtl/uartrx_fifo_pkg.sv
// Shared types and defaults for the UART receive buffer.
package uartrx_fifo_pkg;

  typedef enum logic {
    Receive,
    Ack
  } handshake_state_t;

  localparam int DefaultDepthBitWidth = 4;
  localparam int DefaultDataBitWidth  = 8;

  function automatic int unsigned ring_depth(input int unsigned bits);
    return 32'd1 << bits;
  endfunction

endpackage

// File: rtl/uartrx_fifo_if.sv
// Bus between uartrx/ramio (master side) and the receive buffer (slave side).
interface uartrx_fifo_if
  import uartrx_fifo_pkg::*;
#(
  parameter int DepthBitWidth = DefaultDepthBitWidth,
  parameter int DataBitWidth  = DefaultDataBitWidth
);

  logic [DataBitWidth-1:0]  rx_data;
  logic                     rx_data_ready;
  logic                     rx_go;
  logic                     pop;
  logic [DataBitWidth-1:0]  data_out;
  logic                     empty;
  logic                     full;
  logic [DepthBitWidth:0]   count;
  logic                     overrun;
  logic                     clear_overrun;

  modport master (
    output rx_data, rx_data_ready, pop, clear_overrun,
    input  rx_go, data_out, empty, full, count, overrun
  );

  modport slave (
    input  rx_data, rx_data_ready, pop, clear_overrun,
    output rx_go, data_out, empty, full, count, overrun
  );

endinterface

// File: rtl/uartrx_fifo_fifo_ring.sv
// Generic ring buffer: storage, natural-wrap pointers and an occupancy count.
// The caller must not push while full unless it pops in the same cycle.
module fifo_ring
  import uartrx_fifo_pkg::*;
#(
  parameter int DepthBitWidth = DefaultDepthBitWidth,
  parameter int DataBitWidth  = DefaultDataBitWidth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DataBitWidth-1:0]  push_data,
  input  logic                     pop,
  output logic [DataBitWidth-1:0]  head,
  output logic [DepthBitWidth:0]   count
);

  localparam int Depth = 1 << DepthBitWidth;

  typedef logic [DepthBitWidth-1:0] ptr_t;
  typedef logic [DepthBitWidth:0]   cnt_t;

  localparam ptr_t PtrOne = ptr_t'(1);
  localparam cnt_t CntOne = cnt_t'(1);

  logic [DataBitWidth-1:0] mem [Depth];
  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t count_q;
  logic do_pop;

  // A pop on an empty ring is silently ignored.
  assign do_pop = pop && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrOne;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PtrOne;
      end
      if (push && !do_pop) begin
        count_q <= count_q + CntOne;
      end else if (!push && do_pop) begin
        count_q <= count_q - CntOne;
      end
    end
  end

  assign head  = (count_q == '0) ? '0 : mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/uartrx_fifo.sv
// UART receive buffer: owns the uartrx go/ready handshake, queues bytes in a
// ring and reports overrun instead of overwriting when software falls behind.
module uartrx_fifo
  import uartrx_fifo_pkg::*;
#(
  parameter int DepthBitWidth = DefaultDepthBitWidth,
  parameter int DataBitWidth  = DefaultDataBitWidth
) (
  input  logic          clk,
  input  logic          rst,
  uartrx_fifo_if.slave  bus
);

  typedef logic [DepthBitWidth:0] cnt_t;

  localparam cnt_t Depth = cnt_t'(ring_depth(DepthBitWidth));

  handshake_state_t state_q;
  handshake_state_t state_d;
  logic             capture;
  logic             rx_go_c;
  logic             is_full;
  logic             push;
  logic             drop;
  logic             overrun_q;
  cnt_t             count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= Receive;
    end else begin
      state_q <= state_d;
    end
  end

  // Ready is only looked at in Receive, so each ready assertion yields one capture.
  always_comb begin
    state_d = state_q;
    rx_go_c = 1'b1;
    capture = 1'b0;
    case (state_q)
      Receive: begin
        if (bus.rx_data_ready) begin
          capture = 1'b1;
          state_d = Ack;
        end
      end
      Ack: begin
        rx_go_c = 1'b0;
        state_d = Receive;
      end
      default: begin
        state_d = Receive;
      end
    endcase
  end

  // A pop in the same cycle frees the slot, so a full ring can still accept.
  assign is_full = (count == Depth);
  assign push    = capture && (!is_full || bus.pop);
  assign drop    = capture && is_full && !bus.pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (bus.clear_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  fifo_ring #(
    .DepthBitWidth (DepthBitWidth),
    .DataBitWidth  (DataBitWidth)
  ) ring (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.rx_data),
    .pop       (bus.pop),
    .head      (bus.data_out),
    .count     (count)
  );

  assign bus.rx_go   = rx_go_c;
  assign bus.count   = count;
  assign bus.empty   = (count == '0);
  assign bus.full    = is_full;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_uartrx_fifo.sv
// Directed self-checking bench for the UART receive buffer.
module tb_uartrx_fifo;
  import uartrx_fifo_pkg::*;

  localparam int Dbw = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  uartrx_fifo_if #(.DepthBitWidth(Dbw), .DataBitWidth(8)) bus ();

  uartrx_fifo #(.DepthBitWidth(Dbw), .DataBitWidth(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs are held across exactly one rising edge, then returned to idle.
  task automatic applyStimulus(input logic rdy, input logic [7:0] d,
                               input logic p, input logic clr);
    bus.rx_data_ready = rdy;
    bus.rx_data       = d;
    bus.pop           = p;
    bus.clear_overrun = clr;
    step();
    bus.rx_data_ready = 1'b0;
    bus.rx_data       = 8'h00;
    bus.pop           = 1'b0;
    bus.clear_overrun = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.rx_data       = 8'h00;
    bus.rx_data_ready = 1'b0;
    bus.pop           = 1'b0;
    bus.clear_overrun = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    checkOutput("reset_rx_go", 32'(bus.rx_go), 1);
    checkOutput("reset_empty", 32'(bus.empty), 1);
    checkOutput("reset_full", 32'(bus.full), 0);
    checkOutput("reset_data", 32'(bus.data_out), 0);
    checkOutput("reset_count", 32'(bus.count), 0);
    checkOutput("reset_overrun", 32'(bus.overrun), 0);

    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pop_empty_count", 32'(bus.count), 0);
    checkOutput("pop_empty_empty", 32'(bus.empty), 1);
    checkOutput("pop_empty_overrun", 32'(bus.overrun), 0);

    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
    checkOutput("ack_rx_go_low", 32'(bus.rx_go), 0);
    checkOutput("single_count", 32'(bus.count), 1);
    checkOutput("single_data", 32'(bus.data_out), 'h41);
    checkOutput("single_empty", 32'(bus.empty), 0);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
    checkOutput("ack_one_cycle", 32'(bus.rx_go), 1);
    checkOutput("ack_ignores_ready", 32'(bus.count), 1);
    checkOutput("pre_pop_data", 32'(bus.data_out), 'h41);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post_pop_data", 32'(bus.data_out), 0);
    checkOutput("post_pop_empty", 32'(bus.empty), 1);

    for (int i = 0; i < 16; i++) pushByte(8'(8'h30 + i));
    checkOutput("fill_full", 32'(bus.full), 1);
    checkOutput("fill_count", 32'(bus.count), 16);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    checkOutput("drop_acked", 32'(bus.rx_go), 0);
    checkOutput("drop_overrun", 32'(bus.overrun), 1);
    checkOutput("drop_count", 32'(bus.count), 16);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_order", 32'(bus.data_out), 32'(8'h30 + i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", 32'(bus.empty), 1);
    checkOutput("drain_data", 32'(bus.data_out), 0);
    checkOutput("overrun_sticky", 32'(bus.overrun), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("overrun_cleared", 32'(bus.overrun), 0);

    for (int i = 0; i < 16; i++) pushByte(8'(8'h50 + i));
    checkOutput("full_head", 32'(bus.data_out), 'h50);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    checkOutput("full_pushpop_overrun", 32'(bus.overrun), 0);
    checkOutput("full_pushpop_count", 32'(bus.count), 16);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      checkOutput("full_pushpop_order", 32'(bus.data_out), 32'(8'h51 + i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("full_pushpop_last", 32'(bus.data_out), 'hAA);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("full_pushpop_empty", 32'(bus.empty), 1);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput("interleave_count", 32'(bus.count), 1);
      checkOutput("interleave_data", 32'(bus.data_out), 32'(i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("interleave_drained", 32'(bus.count), 0);
    end

    for (int i = 0; i < 4; i++) pushByte(8'(8'h10 + i));
    applyStimulus(1'b1, 8'h14, 1'b0, 1'b0);
    checkOutput("midack_count", 32'(bus.count), 5);
    checkOutput("midack_rx_go", 32'(bus.rx_go), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_count", 32'(bus.count), 0);
    checkOutput("rst_rx_go", 32'(bus.rx_go), 1);
    checkOutput("rst_data", 32'(bus.data_out), 0);
    checkOutput("rst_empty", 32'(bus.empty), 1);

    for (int i = 0; i < 16; i++) pushByte(8'(8'h60 + i));
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    checkOutput("set_clear_same_cycle", 32'(bus.overrun), 1);
    checkOutput("set_clear_count", 32'(bus.count), 16);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("set_clear_later", 32'(bus.overrun), 0);
    checkOutput("set_clear_head", 32'(bus.data_out), 'h60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
